// File: rtl/fifo_burst_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_drain_ctrl
// Brief    : Drains the async FIFO read side into DDR3 write command/data bursts.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_drain_ctrl #(
  parameter int A_SIZE    = 12,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 8,
  parameter int ADDR_STEP = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic              i_fifo_empty,
  input  logic [A_SIZE:0]   i_fifo_level,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd_en,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [ADDR_W-1:0] o_cmd_addr,
  output logic [7:0]        o_cmd_len,
  output logic              o_wr_valid,
  input  logic              i_wr_ready,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_wr_last,
  output logic              o_busy,
  output logic [15:0]       o_burst_cnt
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_cmd  = 2'd1;
  localparam logic [1:0] c_st_data = 2'd2;

  localparam logic [A_SIZE:0]   c_burst_lvl = (A_SIZE+1)'(BURST_LEN);
  localparam logic [7:0]        c_burst_len = 8'(BURST_LEN);
  localparam logic [15:0]       c_timeout   = 16'(TIMEOUT);
  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(ADDR_STEP);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_timer;
  logic [7:0]        r_rd_issued;
  logic              r_inflight;
  logic [1:0]        r_buf_cnt;
  logic [DATA_W-1:0] r_buf0;
  logic [DATA_W-1:0] r_buf1;
  logic [7:0]        r_beat_cnt;
  logic [15:0]       r_burst_cnt;

  logic              w_start_full;
  logic              w_has_words;
  logic              w_timeout;
  logic              w_start;
  logic [7:0]        w_start_len;
  logic              w_wr_valid;
  logic              w_pop;
  logic [2:0]        w_occ;
  logic              w_rd_en;
  logic              w_last_beat;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr_inc;

  // A full burst wins over flush/timeout; a partial length always fits in 8 bits.
  assign w_start_full = (i_fifo_level >= c_burst_lvl);
  assign w_has_words  = (i_fifo_level != '0);
  assign w_timeout    = (r_timer == c_timeout);
  assign w_start      = i_enable & (w_start_full | (w_has_words & (i_flush | w_timeout)));
  assign w_start_len  = w_start_full ? c_burst_len : 8'(i_fifo_level);

  assign w_wr_valid  = (r_state == c_st_data) && (r_buf_cnt != 2'd0);
  assign w_pop       = w_wr_valid & i_wr_ready;
  assign w_last_beat = ((r_beat_cnt + 8'd1) == r_len);
  assign w_done      = w_pop & w_last_beat;

  // Words held or arriving after this cycle; never allowed to exceed the two buffer slots.
  assign w_occ   = {1'b0, r_buf_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en = (r_state != c_st_idle) & ~i_fifo_empty &
                   (r_rd_issued < r_len) & (w_occ < 3'd2);

  assign w_addr_inc = ADDR_W'(r_len) * c_addr_step;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (w_start)     w_next_state = c_st_cmd;
      c_st_cmd:  if (i_cmd_ready) w_next_state = c_st_data;
      c_st_data: if (w_done)      w_next_state = c_st_idle;
      default:                    w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    o_cmd_valid  = (r_state == c_st_cmd);
    o_busy       = (r_state != c_st_idle);
    o_wr_valid   = w_wr_valid;
    o_wr_last    = w_wr_valid & w_last_beat;
    o_fifo_rd_en = w_rd_en;
  end

  assign o_cmd_addr  = r_addr;
  assign o_cmd_len   = r_len;
  assign o_wr_data   = r_buf0;
  assign o_burst_cnt = r_burst_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_timer <= 16'd0;
    end else if ((r_state == c_st_idle) && !w_start && i_enable && w_has_words && !w_start_full) begin
      r_timer <= r_timer + 16'd1;
    end else begin
      r_timer <= 16'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_len       <= 8'd0;
      r_rd_issued <= 8'd0;
      r_inflight  <= 1'b0;
      r_beat_cnt  <= 8'd0;
    end else begin
      if ((r_state == c_st_idle) && w_start) begin
        r_len       <= w_start_len;
        r_rd_issued <= 8'd0;
        r_beat_cnt  <= 8'd0;
      end else begin
        if (w_rd_en) r_rd_issued <= r_rd_issued + 8'd1;
        if (w_pop)   r_beat_cnt  <= r_beat_cnt + 8'd1;
      end
      r_inflight <= w_rd_en;
    end
  end

  // Two-slot output buffer: r_buf0 is always the head presented on o_wr_data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_buf_cnt <= 2'd0;
      r_buf0    <= '0;
      r_buf1    <= '0;
    end else begin
      case ({r_inflight, w_pop})
        2'b10: begin
          if (r_buf_cnt == 2'd0) r_buf0 <= i_fifo_data;
          else                   r_buf1 <= i_fifo_data;
          r_buf_cnt <= r_buf_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0    <= r_buf1;
          r_buf_cnt <= r_buf_cnt - 2'd1;
        end
        2'b11: begin
          if (r_buf_cnt == 2'd1) begin
            r_buf0 <= i_fifo_data;
          end else begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_fifo_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_burst_cnt <= 16'd0;
    end else begin
      if ((r_state == c_st_idle) && i_addr_load) begin
        r_addr <= i_base_addr;
      end else if (w_done) begin
        r_addr <= r_addr + w_addr_inc;
      end
      if (w_done) r_burst_cnt <= r_burst_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_drain_ctrl
// Brief    : Scoreboard bench for fifo_burst_drain_ctrl with a behavioural FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_drain_ctrl;

  localparam int TIMEOUT = 16;

  typedef struct packed { logic [27:0] addr; logic [7:0] len; } cmd_t;
  typedef struct packed { logic [31:0] data; logic last; } beat_t;

  logic        clk = 1'b0;
  logic        rst, enable, flush, addr_load, cmd_ready, wr_ready;
  logic [27:0] base_addr;
  logic        fifo_empty = 1'b1;
  logic [12:0] fifo_level = '0;
  logic [31:0] fifo_data  = '0;
  logic        o_fifo_rd_en, o_cmd_valid, o_wr_valid, o_wr_last, o_busy;
  logic [27:0] o_cmd_addr;
  logic [7:0]  o_cmd_len;
  logic [31:0] o_wr_data;
  logic [15:0] o_burst_cnt;

  logic [31:0] fifo_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] exp_data[$];
  cmd_t        exp_cmd_q[$];
  beat_t       exp_beat_q[$];

  int n_cmp = 0, n_fail = 0;
  int rd_total = 0, pop_total = 0, beat_total = 0;
  int serial = 0, n, k, b0, bad;
  logic fifo_clear = 1'b0, rand_wr = 1'b0;

  fifo_burst_drain_ctrl #(.A_SIZE(12), .DATA_W(32), .ADDR_W(28), .BURST_LEN(8),
                          .ADDR_STEP(8), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(enable), .i_flush(flush),
    .i_addr_load(addr_load), .i_base_addr(base_addr),
    .i_fifo_empty(fifo_empty), .i_fifo_level(fifo_level), .i_fifo_data(fifo_data),
    .o_fifo_rd_en(o_fifo_rd_en), .o_cmd_valid(o_cmd_valid), .i_cmd_ready(cmd_ready),
    .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len), .o_wr_valid(o_wr_valid),
    .i_wr_ready(wr_ready), .o_wr_data(o_wr_data), .o_wr_last(o_wr_last),
    .o_busy(o_busy), .o_burst_cnt(o_burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push_words(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      pend_q.push_back(32'hC0DE_0000 + 32'(serial));
      exp_data.push_back(32'hC0DE_0000 + 32'(serial));
      serial++;
    end
  endtask

  task automatic exp_cmd(input logic [27:0] addr, input int len);
    cmd_t c;
    beat_t b;
    c.addr = addr;
    c.len  = 8'(len);
    exp_cmd_q.push_back(c);
    for (int i = 0; i < len; i++) begin
      b.data = exp_data.pop_front();
      b.last = (i == len - 1);
      exp_beat_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((exp_cmd_q.size() != 0 || exp_beat_q.size() != 0 || o_busy) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, longint'(c < budget), 1);
  endtask

  // Behavioural FIFO: one-cycle read latency, writes become visible at the next edge.
  initial forever begin
    @(posedge clk);
    if (fifo_clear) begin
      fifo_q.delete();
    end else if (o_fifo_rd_en) begin
      n_cmp++;
      if (fifo_q.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_underflow: got read with level 0 expected no read");
      end else begin
        fifo_data <= fifo_q.pop_front();
      end
    end
    while (pend_q.size() != 0) fifo_q.push_back(pend_q.pop_front());
    fifo_level <= 13'(fifo_q.size());
    fifo_empty <= (fifo_q.size() == 0);
  end

  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      wr_ready = rand_wr ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold/read-ahead rules.
  initial begin
    logic        p_cmd_stall = 0, p_wr_stall = 0, p_last_acc = 0, p_wr_last = 0;
    logic [27:0] p_addr = 0;
    logic [7:0]  p_len = 0;
    logic [31:0] p_data = 0;
    cmd_t  c;
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_cmd_stall = 0; p_wr_stall = 0; p_last_acc = 0;
      end else begin
        if (p_cmd_stall) begin
          n_cmp++;
          if (!o_cmd_valid || o_cmd_addr != p_addr || o_cmd_len != p_len) begin
            n_fail++;
            $display("FAIL cmd_hold: got v=%0b addr=%h len=%0d expected v=1 addr=%h len=%0d",
                     o_cmd_valid, o_cmd_addr, o_cmd_len, p_addr, p_len);
          end
        end
        if (p_wr_stall) begin
          n_cmp++;
          if (!o_wr_valid || o_wr_data != p_data || o_wr_last != p_wr_last) begin
            n_fail++;
            $display("FAIL wr_hold: got v=%0b data=%h last=%0b expected v=1 data=%h last=%0b",
                     o_wr_valid, o_wr_data, o_wr_last, p_data, p_wr_last);
          end
        end
        if (p_last_acc) chk("idle_gap_cmd_valid", longint'(o_cmd_valid), 0);
        if (o_cmd_valid && cmd_ready) begin
          n_cmp++;
          if (exp_cmd_q.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_unexpected: got addr=%h len=%0d expected none", o_cmd_addr, o_cmd_len);
          end else begin
            c = exp_cmd_q.pop_front();
            if (o_cmd_addr != c.addr || o_cmd_len != c.len) begin
              n_fail++;
              $display("FAIL cmd: got addr=%h len=%0d expected addr=%h len=%0d",
                       o_cmd_addr, o_cmd_len, c.addr, c.len);
            end
          end
        end
        if (o_wr_valid && wr_ready) begin
          n_cmp++;
          beat_total++;
          if (exp_beat_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: got data=%h expected none", o_wr_data);
          end else begin
            b = exp_beat_q.pop_front();
            if (o_wr_data != b.data || o_wr_last != b.last) begin
              n_fail++;
              $display("FAIL beat: got data=%h last=%0b expected data=%h last=%0b",
                       o_wr_data, o_wr_last, b.data, b.last);
            end
          end
        end
        if (o_fifo_rd_en) rd_total++;
        if (o_wr_valid && wr_ready) pop_total++;
        if (o_fifo_rd_en) chk("read_ahead_le2", longint'((rd_total - pop_total) <= 2), 1);
        p_cmd_stall = o_cmd_valid && !cmd_ready;
        p_addr      = o_cmd_addr;
        p_len       = o_cmd_len;
        p_wr_stall  = o_wr_valid && !wr_ready;
        p_data      = o_wr_data;
        p_wr_last   = o_wr_last;
        p_last_acc  = o_wr_valid && wr_ready && o_wr_last;
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, longint'({o_cmd_valid, o_wr_valid, o_wr_last, o_fifo_rd_en, o_busy}), 0);
    chk({tag, "_burst_cnt"}, longint'(o_burst_cnt), 0);
    chk({tag, "_cmd_addr"}, longint'(o_cmd_addr), 0);
    chk({tag, "_cmd_len"}, longint'(o_cmd_len), 0);
    chk({tag, "_wr_data"}, longint'(o_wr_data), 0);
  endtask

  task automatic load_addr(input logic [27:0] a);
    base_addr = a; addr_load = 1'b1;
    @(posedge clk); #1;
    addr_load = 1'b0;
  endtask

  initial begin
    rst = 1; enable = 0; flush = 0; addr_load = 0; base_addr = '0; cmd_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 0; enable = 1;
    @(posedge clk); #1;

    // Full burst at 0x100, then a 1-word flush burst at 0x140
    load_addr(28'h100);
    push_words(8); exp_cmd(28'h100, 8);
    n = 0;
    while (!o_cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("start_latency", n, 2);
    k = 0;
    while (!(o_wr_valid && o_wr_last) && k < 50) begin @(posedge clk); #1; k++; end
    chk("cmd_to_last_beat", k, 9);
    wait_drain("drain_t1", 100);
    chk("burst_cnt_t1", longint'(o_burst_cnt), 1);
    push_words(1); exp_cmd(28'h140, 1);
    @(posedge clk); #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    wait_drain("drain_t1b", 100);
    chk("burst_cnt_t1b", longint'(o_burst_cnt), 2);

    // 20 words: two full bursts then a timeout flush of the remaining 4
    load_addr(28'h0);
    push_words(20);
    exp_cmd(28'h000, 8); exp_cmd(28'h040, 8); exp_cmd(28'h080, 4);
    wait_drain("drain_t2", 400);
    chk("burst_cnt_t2", longint'(o_burst_cnt), 5);

    // Timeout latency measured from the first cycle the level is nonzero
    push_words(2); exp_cmd(28'h0A0, 2);
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      #1;
      if (o_cmd_valid) break;
      @(posedge clk);
      n++;
    end
    chk("timeout_latency", n, TIMEOUT + 1);
    wait_drain("drain_t3", 100);

    // Flush with 3 words, then flush with an empty FIFO
    push_words(3); exp_cmd(28'h0B0, 3);
    @(posedge clk); #1; flush = 1;
    @(posedge clk); #1; flush = 0;
    chk("flush_latency", longint'(o_cmd_valid), 1);
    wait_drain("drain_t4", 100);
    chk("burst_cnt_t4", longint'(o_burst_cnt), 7);
    flush = 1;
    @(posedge clk); #1; flush = 0;
    bad = 0;
    repeat (6) begin @(posedge clk); #1; if (o_busy || o_cmd_valid) bad = 1; end
    chk("flush_empty_idle", bad, 0);

    // Backpressure: command stalled 5 cycles, random write ready, ignored address load
    cmd_ready = 0; rand_wr = 1;
    push_words(8); exp_cmd(28'h0C8, 8);
    n = 0;
    while (!o_cmd_valid && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    base_addr = 28'hDEAD0; addr_load = 1;
    @(posedge clk); #1;
    addr_load = 0; base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    cmd_ready = 1;
    wait_drain("drain_t5", 400);
    rand_wr = 0;
    @(posedge clk); #1;
    chk("burst_cnt_t5", longint'(o_burst_cnt), 8);

    // Reset after beat 4 of an 8-beat burst at 0x108
    push_words(8); exp_cmd(28'h108, 8);
    b0 = beat_total; n = 0;
    while (beat_total < b0 + 4 && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_beat4", longint'(n < 100), 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk_all_zero("midburst_reset");
    exp_cmd_q.delete(); exp_beat_q.delete(); exp_data.delete();
    rd_total = 0; pop_total = 0;
    fifo_clear = 1;
    @(posedge clk); #1;
    fifo_clear = 0;
    push_words(8); exp_cmd(28'h000, 8);
    wait_drain("drain_t6", 100);
    chk("burst_cnt_t6", longint'(o_burst_cnt), 1);

    // Address wrap at the top of the address space
    load_addr(28'hFFFFFE0);
    push_words(16); exp_cmd(28'hFFFFFE0, 8); exp_cmd(28'h0000020, 8);
    wait_drain("drain_t7", 200);
    chk("burst_cnt_t7", longint'(o_burst_cnt), 3);

    chk("exp_cmd_left", exp_cmd_q.size(), 0);
    chk("exp_beat_left", exp_beat_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
